// File: rtl/pb_evt_pkg.sv
// Shared types and helpers for the push-button event arbiter.
package pb_evt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int MAX_PB  = 16;
    localparam int MAX_IDW = $clog2(MAX_PB);

    // Round-robin pick: first set bit at or above ptr, wrapping at MAX_PB.
    // Callers zero-extend narrower pend vectors, so the unused upper bits
    // never win and the wrap behaves as if it were at the real channel count.
    function automatic logic [MAX_IDW-1:0] next_rr(
        input logic [MAX_PB-1:0]  pend,
        input logic [MAX_IDW-1:0] ptr
    );
        logic [MAX_IDW-1:0] idx;
        logic [MAX_IDW-1:0] grant;
        logic               found;
        grant = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_PB; k++) begin
            idx = ptr + MAX_IDW'(k);
            if (!found && pend[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/pb_event_arbiter_if.sv
// Event handshake and status bundle between the arbiter and its consumer.
interface pb_event_arbiter_if #(
    parameter int NUM_PB = 4
);
    localparam int IDW = $clog2(NUM_PB);

    logic              evt_vld;
    logic              evt_rdy;
    logic [IDW-1:0]    evt_id;
    logic [NUM_PB-1:0] pend;
    logic [NUM_PB-1:0] ovf;
    logic              ovf_clr;

    modport master (
        output evt_vld, evt_id, pend, ovf,
        input  evt_rdy, ovf_clr
    );

    modport slave (
        input  evt_vld, evt_id, pend, ovf,
        output evt_rdy, ovf_clr
    );

endinterface

// File: rtl/pb_rise_sync.sv
// Three-flop synchronizer for one raw button pin with rising-edge detect.
module pb_rise_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 is the delayed copy used for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/pb_event_arbiter.sv
// Collects debounced button rises and offers them round-robin on a
// valid/ready handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing offered; grant the next pending channel if any
//   OFFER | evt_vld high, evt_id frozen until the consumer takes it
module pb_event_arbiter
    import pb_evt_pkg::*;
#(
    parameter int NUM_PB      = 4,
    parameter int LOCKOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PB-1:0] pb_in,
    pb_event_arbiter_if.master bus
);
    localparam int IDW = $clog2(NUM_PB);
    localparam int LW  = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    evt_id_q;
    logic [IDW-1:0]    evt_id_nxt;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    ptr_nxt;
    logic [IDW-1:0]    grant;
    logic [NUM_PB-1:0] rise;
    logic [NUM_PB-1:0] accept;
    logic [NUM_PB-1:0] hs_vec;
    logic [NUM_PB-1:0] pend_q;
    logic [NUM_PB-1:0] ovf_q;
    logic [NUM_PB-1:0] pend_nxt;
    logic [NUM_PB-1:0] ovf_nxt;
    logic              hs;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        logic [LW-1:0] lock_cnt;

        pb_rise_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .sig  (pb_in[i]),
            .rise (rise[i])
        );

        assign accept[i] = rise[i] & (lock_cnt == '0);

        // Lockout down-counter: reloaded only by an accepted rise, so
        // bounces inside the window neither register nor extend it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lock_cnt <= '0;
            end else if (accept[i]) begin
                lock_cnt <= LW'(LOCKOUT_CYC);
            end else if (lock_cnt != '0) begin
                lock_cnt <= lock_cnt - LW'(1);
            end
        end
    end

    assign hs    = (state == OFFER) & bus.evt_rdy;
    assign grant = IDW'(next_rr(MAX_PB'(pend_q), MAX_IDW'(ptr_q)));

    // Decode the handshake to a one-hot channel vector.
    always_comb begin
        hs_vec = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            hs_vec[i] = hs & (evt_id_q == IDW'(i));
        end
    end

    // A fresh rise on a channel being handshaken re-arms it without overflow.
    assign pend_nxt = accept | (pend_q & ~hs_vec);
    assign ovf_nxt  = bus.ovf_clr ? '0 : (ovf_q | (accept & pend_q & ~hs_vec));

    // Pending and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    // FSM state, latched grant and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            evt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state    <= state_nxt;
            evt_id_q <= evt_id_nxt;
            ptr_q    <= ptr_nxt;
        end
    end

    // Next-state logic; the grant is only sampled on IDLE->OFFER so the
    // offered id stays put while other channels come and go.
    always_comb begin
        state_nxt  = state;
        evt_id_nxt = evt_id_q;
        ptr_nxt    = ptr_q;
        case (state)
            IDLE: begin
                if (|pend_q) begin
                    state_nxt  = OFFER;
                    evt_id_nxt = grant;
                end
            end
            OFFER: begin
                if (bus.evt_rdy) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (evt_id_q == IDW'(NUM_PB - 1)) ? '0 : evt_id_q + IDW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.evt_vld = (state == OFFER);
    assign bus.evt_id  = evt_id_q;
    assign bus.pend    = pend_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter: directed table, corner
// sequences and randomized traffic against a rule-level reference model.
module tb_pb_event_arbiter;
    localparam int N = 4;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pb_in;

    pb_event_arbiter_if #(.NUM_PB(N)) bus ();

    pb_event_arbiter #(.NUM_PB(N), .LOCKOUT_CYC(L)) dut (
        .clk   (clk),
        .rst   (rst),
        .pb_in (pb_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rise cycles come from the pin history, lockout from
    // the distance to the last accepted rise cycle.
    bit m_vld;
    int m_id;
    int m_ptr;
    bit m_pend[N];
    bit m_ovf[N];
    int last_acc[N];
    bit p1[N], p2[N], p3[N];
    int edge_n = 0;

    function automatic void model_reset();
        m_vld = 0; m_id = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; last_acc[i] = -1000;
            p1[i] = 0; p2[i] = 0; p3[i] = 0;
        end
    endfunction

    function automatic void model_update();
        bit hs, hit, any;
        bit acc[N];
        bit np[N];
        edge_n++;
        hs = m_vld && bus.evt_rdy;
        for (int i = 0; i < N; i++) begin
            acc[i] = p2[i] && !p3[i] && (edge_n - last_acc[i] >= L + 1);
            if (acc[i]) last_acc[i] = edge_n;
            hit = hs && (m_id == i);
            np[i] = acc[i] || (m_pend[i] && !hit);
            m_ovf[i] = bus.ovf_clr ? 1'b0 : (m_ovf[i] || (acc[i] && m_pend[i] && !hit));
        end
        if (!m_vld) begin
            any = 0;
            for (int k = 0; k < N; k++) begin
                if (!any && m_pend[(m_ptr + k) % N]) begin
                    any = 1;
                    m_id = (m_ptr + k) % N;
                end
            end
            if (any) m_vld = 1;
        end else if (hs) begin
            m_vld = 0;
            m_ptr = (m_id + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i];
            p3[i] = p2[i]; p2[i] = p1[i]; p1[i] = pb_in[i];
        end
    endfunction

    task automatic compare_model();
        logic [N-1:0] ep, eo;
        for (int i = 0; i < N; i++) begin
            ep[i] = m_pend[i];
            eo[i] = m_ovf[i];
        end
        check("model_vld", bus.evt_vld, m_vld);
        check("model_id", bus.evt_id, m_id);
        check("model_pend", bus.pend, ep);
        check("model_ovf", bus.ovf, eo);
    endtask

    task automatic tick();
        if (!rst && bus.evt_vld && bus.evt_rdy) hs_log.push_back(int'(bus.evt_id));
        if (rst) model_reset(); else model_update();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        #4;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]      pins;
        int                n;
        logic [3:0][1:0]   ids;
    } vec_t;

    vec_t vecs[5];
    int   ch;
    int   budget;

    initial begin
        vecs[0] = '{pins: 4'b1011, n: 3, ids: {2'd0, 2'd3, 2'd1, 2'd0}};
        vecs[1] = '{pins: 4'b1001, n: 2, ids: {2'd0, 2'd0, 2'd3, 2'd0}};
        vecs[2] = '{pins: 4'b0100, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[3] = '{pins: 4'b0011, n: 2, ids: {2'd0, 2'd0, 2'd1, 2'd0}};
        vecs[4] = '{pins: 4'b1111, n: 4, ids: {2'd1, 2'd0, 2'd3, 2'd2}};

        rst = 1'b1;
        pb_in = '0;
        bus.evt_rdy = 1'b0;
        bus.ovf_clr = 1'b0;
        do_reset();

        // Reset values hold with quiet inputs.
        repeat (20) begin
            tick();
            check("rst_vld", bus.evt_vld, 1'b0);
            check("rst_id", bus.evt_id, '0);
            check("rst_pend", bus.pend, '0);
            check("rst_ovf", bus.ovf, '0);
        end

        // Single event latency.
        bus.evt_rdy = 1'b1;
        pb_in[2] = 1'b1;
        tick();
        tick();
        check("lat_e2_pend", bus.pend, 4'b0000);
        tick();
        check("lat_e3_pend", bus.pend, 4'b0100);
        check("lat_e3_vld", bus.evt_vld, 1'b0);
        tick();
        check("lat_e4_vld", bus.evt_vld, 1'b1);
        check("lat_e4_id", bus.evt_id, 2);
        tick();
        check("lat_e5_vld", bus.evt_vld, 1'b0);
        check("lat_e5_pend", bus.pend, 4'b0000);
        pb_in = '0;
        repeat (30) tick();

        // Round-robin table from a fresh pointer.
        do_reset();
        for (int v = 0; v < 5; v++) begin
            hs_log.delete();
            pb_in = vecs[v].pins;
            bus.evt_rdy = 1'b1;
            repeat (20) tick();
            pb_in = '0;
            check("rr_count", hs_log.size(), vecs[v].n);
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k < hs_log.size()) check("rr_id", hs_log[k], vecs[v].ids[k]);
            end
            repeat (30) tick();
        end

        // Backpressure and overflow on channel 1.
        bus.evt_rdy = 1'b0;
        hs_log.delete();
        pb_in[1] = 1'b1;
        tick();
        pb_in[1] = 1'b0;
        repeat (L + 1) tick();
        pb_in[1] = 1'b1;
        tick();
        repeat (4) tick();
        check("bp_ovf", bus.ovf, 4'b0010);
        check("bp_vld", bus.evt_vld, 1'b1);
        check("bp_id", bus.evt_id, 1);
        pb_in[1] = 1'b0;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("bp_ovf_clr", bus.ovf, 4'b0000);
        check("bp_id_held", bus.evt_id, 1);
        bus.evt_rdy = 1'b1;
        repeat (10) tick();
        check("bp_count", hs_log.size(), 1);
        if (hs_log.size() > 0) check("bp_hs_id", hs_log[0], 1);
        repeat (20) tick();

        // Lockout: bouncing channel 0 yields one event.
        hs_log.delete();
        for (int b = 0; b < 4; b++) begin
            pb_in[0] = 1'b1;
            tick();
            pb_in[0] = 1'b0;
            tick();
            tick();
        end
        repeat (20) tick();
        check("lock_count", hs_log.size(), 1);
        check("lock_ovf0", bus.ovf[0], 1'b0);
        repeat (10) tick();
        hs_log.delete();
        pb_in[0] = 1'b1;
        repeat (8) tick();
        check("lock_second", hs_log.size(), 1);
        if (hs_log.size() > 0) check("lock_second_id", hs_log[0], 0);
        pb_in[0] = 1'b0;
        repeat (20) tick();

        // Reset during OFFER with pins held across release.
        bus.evt_rdy = 1'b0;
        pb_in = 4'b1001;
        budget = 0;
        while (!bus.evt_vld && budget < 10) begin
            tick();
            budget++;
        end
        check("mid_offer_vld", bus.evt_vld, 1'b1);
        check("mid_offer_id", bus.evt_id, 3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", bus.evt_vld, 1'b0);
        check("mid_rst_pend", bus.pend, '0);
        check("mid_rst_ovf", bus.ovf, '0);
        model_reset();
        tick();
        tick();
        #4;
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rel_e3_vld", bus.evt_vld, 1'b0);
        tick();
        check("rel_e4_vld", bus.evt_vld, 1'b1);
        check("rel_e4_id", bus.evt_id, 0);
        hs_log.delete();
        bus.evt_rdy = 1'b1;
        repeat (6) tick();
        check("rel_count", hs_log.size(), 2);
        if (hs_log.size() > 1) begin
            check("rel_id0", hs_log[0], 0);
            check("rel_id1", hs_log[1], 3);
        end
        pb_in = '0;
        repeat (20) tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                ch = int'($urandom_range(0, N - 1));
                pb_in[ch] = ~pb_in[ch];
            end
            bus.evt_rdy = ($urandom_range(0, 2) != 0);
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
